// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmit path and the future receive path:
//   FSM state encoding, parity mode constants and the baud divider function.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Frame FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Parity modes.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per bit cell, rounded to the nearest integer.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
//   Restartable bit-cell counter running 0..DIV-1. A restart forces the count to
//   0, so cells are phase-aligned to the start bit.
// Ports:
//   clk       in   system clock
//   rst_x     in   asynchronous active-low reset
//   restart   in   hold the counter at 0 (asserted while the transmitter idles)
//   cell_end  out  high while the count is DIV-1 (last clock of a bit cell)
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rst_x,
    input  logic restart,
    output logic cell_end
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign cell_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Byte-wide asynchronous serial transmitter. Frames a byte as start bit,
//   DATA_BITS data bits LSB first, optional parity and STOP_BITS stop bits.
// Ports:
//   clk    in   system clock, rising edge
//   rst_x  in   asynchronous active-low reset; aborts any frame in progress
//   data   in   byte to send, sampled only on the accept edge
//   valid  in   data is offered
//   ready  out  block can accept (transfer = valid & ready at a rising edge)
//   busy   out  a frame is in progress
//   txd    out  serial line, idle/mark = 1
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_x,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 busy,
    output logic                 txd
);

    import uart_pkg::*;

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int IDX_W = $clog2(DATA_BITS);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx: DIV=%0d must be at least 2", DIV);
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS=%0d outside 5..8", DATA_BITS);
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY=%0d must be 0, 1 or 2", PARITY);
    end

    // The PARITY parameter shadows the imported state name, so state labels
    // are written with explicit package scope throughout.
    uart_state_e          state;
    logic [DATA_BITS-1:0] shreg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 par_acc;
    logic                 cell_end;

    // Counter sits at 0 while idle, so the first cell starts exactly on accept.
    uart_baud_cnt #(.DIV(DIV)) u_baud_cnt (
        .clk      (clk),
        .rst_x    (rst_x),
        .restart  (state == uart_pkg::IDLE),
        .cell_end (cell_end)
    );

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state    <= uart_pkg::IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_acc  <= 1'b0;
            txd      <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                uart_pkg::IDLE: begin
                    if (valid && ready) begin
                        state    <= uart_pkg::START;
                        shreg    <= data;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        par_acc  <= 1'b0;
                        txd      <= 1'b0;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                uart_pkg::START: begin
                    if (cell_end) begin
                        state   <= uart_pkg::DATA;
                        txd     <= shreg[0];
                        par_acc <= par_acc ^ shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                    end
                end

                uart_pkg::DATA: begin
                    if (cell_end) begin
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            if (PARITY != PAR_NONE) begin
                                state <= uart_pkg::PARITY;
                                // par_acc holds the XOR of every data bit sent.
                                txd   <= (PARITY == PAR_ODD) ? ~par_acc : par_acc;
                            end else begin
                                state <= uart_pkg::STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            txd     <= shreg[0];
                            par_acc <= par_acc ^ shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end

                uart_pkg::PARITY: begin
                    if (cell_end) begin
                        state <= uart_pkg::STOP;
                        txd   <= 1'b1;
                    end
                end

                uart_pkg::STOP: begin
                    if (cell_end) begin
                        if (STOP_BITS == 1 || stop_idx == 1'b1) begin
                            state <= uart_pkg::IDLE;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= uart_pkg::IDLE;
                    txd   <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Directed bench for uart_tx. Four instances cover 8N1 (DIV=16), 8E2, 8O2 and
//   the board defaults (DIV=434); 'sel' routes one of them to the monitor.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_x;
    logic [7:0] data;
    logic       tb_valid;
    int         sel;

    int errors = 0;
    int checks = 0;

    // 50 MHz clock: 20 ns period.
    always #10 clk = ~clk;

    logic ready_n1, busy_n1, txd_n1;
    logic ready_e2, busy_e2, txd_e2;
    logic ready_o2, busy_o2, txd_o2;
    logic ready_df, busy_df, txd_df;
    logic mon_ready, mon_busy, mon_txd;

    uart_tx #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .rst_x(rst_x), .data(data), .valid(tb_valid && sel == 0),
        .ready(ready_n1), .busy(busy_n1), .txd(txd_n1));

    uart_tx #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_e2 (
        .clk(clk), .rst_x(rst_x), .data(data), .valid(tb_valid && sel == 1),
        .ready(ready_e2), .busy(busy_e2), .txd(txd_e2));

    uart_tx #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_o2 (
        .clk(clk), .rst_x(rst_x), .data(data), .valid(tb_valid && sel == 2),
        .ready(ready_o2), .busy(busy_o2), .txd(txd_o2));

    uart_tx #(.CLK_HZ(50000000), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_df (
        .clk(clk), .rst_x(rst_x), .data(data), .valid(tb_valid && sel == 3),
        .ready(ready_df), .busy(busy_df), .txd(txd_df));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        mon_ready = 1'b1;
        mon_busy  = 1'b0;
        mon_txd   = 1'b1;
        case (sel)
            0: begin mon_ready = ready_n1; mon_busy = busy_n1; mon_txd = txd_n1; end
            1: begin mon_ready = ready_e2; mon_busy = busy_e2; mon_txd = txd_e2; end
            2: begin mon_ready = ready_o2; mon_busy = busy_o2; mon_txd = txd_o2; end
            3: begin mon_ready = ready_df; mon_busy = busy_df; mon_txd = txd_df; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer byte d to the selected instance and follow the frame until ready
    // returns. cap[k] is TXD sampled mid-cell k (cell 0 = start bit).
    task automatic send(input string tag, input logic [7:0] d, input logic [7:0] next_d,
                        input bit hold, output logic [15:0] cap, output int low,
                        output int wait_n, output int start_w, output int start_ns);
        int  div;
        int  c;
        int  glitch;
        bit  acc;
        bit  pre;
        bit  seen_one;
        logic cur;
        time t0;
        div      = (sel == 3) ? 434 : 16;
        cap      = '0;
        low      = 0;
        wait_n   = 0;
        start_w  = 0;
        start_ns = 0;
        glitch   = 0;
        seen_one = 1'b0;
        acc      = 1'b0;
        t0       = 0;
        data     = d;
        tb_valid = 1'b1;
        while (!acc && wait_n < 5000) begin
            pre = mon_ready;
            @(posedge clk);
            t0 = $time;
            #1;
            wait_n++;
            if (pre) acc = 1'b1;
        end
        check({tag, "_accepted"}, 32'(acc), 32'd1);
        if (hold) data = next_d;
        else      tb_valid = 1'b0;
        c   = 0;
        cur = mon_txd;
        while (acc && mon_ready == 1'b0 && c < 20 * div) begin
            if (c % div == 0) cur = mon_txd;
            else if (mon_txd !== cur) glitch++;
            if (c % div == div / 2 && c / div < 16) cap[c / div] = mon_txd;
            if (!seen_one && mon_txd === 1'b1) begin
                seen_one = 1'b1;
                start_w  = c;
                start_ns = int'($time - t0 - 1);
            end
            low++;
            tick();
            c++;
        end
        check({tag, "_cells_stable"}, 32'(glitch), 32'd0);
    endtask

    logic [15:0] cap;
    int          low, wait_n, start_w, start_ns;
    int          edges;
    logic        prev_n1, prev_df;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_x    = 1'b0;
        data     = 8'h00;
        tb_valid = 1'b0;
        sel      = 0;

        // 1. Reset held for 3 clocks, then idle line.
        repeat (3) tick();
        check("rst_txd",   32'(txd_n1),   32'd1);
        check("rst_ready", 32'(ready_n1), 32'd1);
        check("rst_busy",  32'(busy_n1),  32'd0);
        rst_x = 1'b1;
        edges   = 0;
        prev_n1 = txd_n1;
        prev_df = txd_df;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (txd_n1 !== prev_n1) edges++;
            if (txd_df !== prev_df) edges++;
            prev_n1 = txd_n1;
            prev_df = txd_df;
        end
        check("idle_no_edge", 32'(edges), 32'd0);
        check("idle_ready",   32'(ready_df), 32'd1);

        // 2. 0x55, 8N1: 0,1,0,1,0,1,0,1,0,1.
        sel = 0;
        send("n1_55", 8'h55, 8'h00, 1'b0, cap, low, wait_n, start_w, start_ns);
        check("n1_55_cells",   32'(cap), 32'h2AA);
        check("n1_55_ready_lo", 32'(low), 32'd160);
        check("n1_55_start_w", 32'(start_w), 32'd16);

        // 3. 0xA5, 8E2: parity 0; then 8O2: parity 1.
        sel = 1;
        send("e2_a5", 8'hA5, 8'h00, 1'b0, cap, low, wait_n, start_w, start_ns);
        check("e2_a5_cells",    32'(cap), 32'hD4A);
        check("e2_a5_ready_lo", 32'(low), 32'd192);
        sel = 2;
        send("o2_a5", 8'hA5, 8'h00, 1'b0, cap, low, wait_n, start_w, start_ns);
        check("o2_a5_cells",    32'(cap), 32'hF4A);
        check("o2_a5_ready_lo", 32'(low), 32'd192);

        // 4. Back-to-back with valid held: one clock of extra mark between frames.
        sel = 0;
        send("b2b_01", 8'h01, 8'h02, 1'b1, cap, low, wait_n, start_w, start_ns);
        check("b2b_01_cells",    32'(cap), 32'h202);
        check("b2b_01_ready_lo", 32'(low), 32'd160);
        send("b2b_02", 8'h02, 8'h03, 1'b1, cap, low, wait_n, start_w, start_ns);
        check("b2b_02_gap",   32'(wait_n), 32'd1);
        check("b2b_02_cells", 32'(cap), 32'h204);
        send("b2b_03", 8'h03, 8'h00, 1'b0, cap, low, wait_n, start_w, start_ns);
        check("b2b_03_gap",   32'(wait_n), 32'd1);
        check("b2b_03_cells", 32'(cap), 32'h206);
        tick();
        check("b2b_no_extra", 32'(busy_n1), 32'd0);

        // 5. Reset pulse in data cell 3 of a 0x00 frame.
        data     = 8'h00;
        tb_valid = 1'b1;
        tick();
        tb_valid = 1'b0;
        check("abort_busy", 32'(busy_n1), 32'd1);
        repeat (69) tick();
        check("abort_pre_txd", 32'(txd_n1), 32'd0);
        #3;
        rst_x = 1'b0;
        #1;
        check("abort_txd",   32'(txd_n1),   32'd1);
        check("abort_ready", 32'(ready_n1), 32'd1);
        check("abort_busy0", 32'(busy_n1),  32'd0);
        repeat (3) tick();
        rst_x = 1'b1;
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (txd_n1 !== 1'b1) edges++;
        end
        check("abort_no_resume", 32'(edges), 32'd0);
        check("abort_ready_rel", 32'(ready_n1), 32'd1);
        send("post_0f", 8'h0F, 8'h00, 1'b0, cap, low, wait_n, start_w, start_ns);
        check("post_0f_cells",    32'(cap), 32'h21E);
        check("post_0f_ready_lo", 32'(low), 32'd160);

        // 6. Defaults: DIV=434, 0x41; start bit 434 clocks = 8680 ns.
        sel = 3;
        send("df_41", 8'h41, 8'h00, 1'b0, cap, low, wait_n, start_w, start_ns);
        check("df_41_start_w",  32'(start_w),  32'd434);
        check("df_41_start_ns", 32'(start_ns), 32'd8680);
        check("df_41_cells",    32'(cap), 32'h282);
        check("df_41_ready_lo", 32'(low), 32'd4340);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
